// File: rtl/fetch_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_queue : LC-3b fetch front end (fetch PC, memory read handshake,    |
// |               DEPTH-entry instruction FIFO, redirect/flush).             |
// | Optional macro FETCH_PERF_EN adds saturating fetch/flush counters.       |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module fetch_queue #(
   parameter int               WIDTH    = 16,
   parameter int               DEPTH    = 4,
   parameter logic [WIDTH-1:0] RESET_PC = '0,
   parameter int               PC_INC   = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic             mem_read,
   output logic [WIDTH-1:0] mem_address,
   input  logic [WIDTH-1:0] mem_rdata,
   input  logic             mem_resp,
   input  logic             redirect,
   input  logic [WIDTH-1:0] redirect_pc,
   output logic             ir_valid,
   input  logic             ir_ready,
   output logic [WIDTH-1:0] ir_out,
   output logic [WIDTH-1:0] ir_pc
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]      perf_fetch_cnt,
   output logic [31:0]      perf_flush_cnt
`endif
);

   localparam int                 PTR_W = $clog2(DEPTH);
   localparam int                 CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0]   FULL  = CNT_W'(DEPTH);
   localparam logic [WIDTH-1:0]   INC   = WIDTH'(PC_INC);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_REQ   = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic               mem_read_q, mem_read_d;
   logic [WIDTH-1:0]   addr_q, addr_d;
   logic [WIDTH-1:0]   fpc_q, fpc_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d, count_mid;
   logic               ir_valid_q, ir_valid_d;
   logic [WIDTH-1:0]   ir_out_q, ir_out_d;
   logic [WIDTH-1:0]   ir_pc_q, ir_pc_d;
   logic [2*WIDTH-1:0] fifo_q [DEPTH];
   logic               push, pop;
   logic [WIDTH-1:0]   fpc_inc;

   always_comb begin
      push       = (state_q == S_REQ) && mem_resp && !redirect;
      pop        = ir_valid_q && ir_ready && !redirect;
      fpc_inc    = fpc_q + INC;
      count_mid  = count_q - CNT_W'(pop);

      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      ir_valid_d = ir_valid_q;
      ir_out_d   = ir_out_q;
      ir_pc_d    = ir_pc_q;

      if (redirect) begin
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         count_d    = '0;
         ir_valid_d = 1'b0;
      end else begin
         rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
         wr_ptr_d   = wr_ptr_q + PTR_W'(push);
         count_d    = count_mid + CNT_W'(push);
         ir_valid_d = (count_d != '0);
         // Head comes from storage unless the FIFO drained and the new word bypasses it.
         if (count_mid != '0) begin
            {ir_pc_d, ir_out_d} = fifo_q[rd_ptr_d];
         end else if (push) begin
            ir_pc_d  = fpc_q;
            ir_out_d = mem_rdata;
         end
      end

      state_d    = state_q;
      mem_read_d = mem_read_q;
      addr_d     = addr_q;
      fpc_d      = fpc_q;

      case (state_q)
         S_IDLE: begin
            if (redirect) begin
               fpc_d = redirect_pc;
            end else if (count_q < FULL) begin
               state_d    = S_REQ;
               mem_read_d = 1'b1;
               addr_d     = fpc_q;
            end
         end
         S_REQ: begin
            if (redirect) begin
               fpc_d = redirect_pc;
               if (mem_resp) begin
                  addr_d = redirect_pc;
               end else begin
                  state_d = S_DRAIN;
               end
            end else if (mem_resp) begin
               fpc_d  = fpc_inc;
               addr_d = fpc_inc;
               if (count_d >= FULL) begin
                  state_d    = S_IDLE;
                  mem_read_d = 1'b0;
               end
            end
         end
         S_DRAIN: begin
            // The outstanding response belongs to a flushed stream; wait it out, then drop it.
            if (redirect) begin
               fpc_d = redirect_pc;
            end
            if (mem_resp) begin
               if (redirect) begin
                  state_d    = S_IDLE;
                  mem_read_d = 1'b0;
               end else begin
                  state_d = S_REQ;
                  addr_d  = fpc_q;
               end
            end
         end
         default: begin
            state_d    = S_IDLE;
            mem_read_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         mem_read_q <= 1'b0;
         addr_q     <= RESET_PC;
         fpc_q      <= RESET_PC;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         ir_valid_q <= 1'b0;
         ir_out_q   <= '0;
         ir_pc_q    <= '0;
      end else begin
         state_q    <= state_d;
         mem_read_q <= mem_read_d;
         addr_q     <= addr_d;
         fpc_q      <= fpc_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         ir_valid_q <= ir_valid_d;
         ir_out_q   <= ir_out_d;
         ir_pc_q    <= ir_pc_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_q[wr_ptr_q] <= {fpc_q, mem_rdata};
      end
   end

   assign mem_read    = mem_read_q;
   assign mem_address = addr_q;
   assign ir_valid    = ir_valid_q;
   assign ir_out      = ir_out_q;
   assign ir_pc       = ir_pc_q;

`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetch_q, perf_fetch_d;
   logic [31:0] perf_flush_q, perf_flush_d;

   always_comb begin
      perf_fetch_d = perf_fetch_q;
      perf_flush_d = perf_flush_q;
      if (push && (perf_fetch_q != 32'hFFFF_FFFF)) begin
         perf_fetch_d = perf_fetch_q + 32'd1;
      end
      if (redirect && (perf_flush_q != 32'hFFFF_FFFF)) begin
         perf_flush_d = perf_flush_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_fetch_q <= '0;
         perf_flush_q <= '0;
      end else begin
         perf_fetch_q <= perf_fetch_d;
         perf_flush_q <= perf_flush_d;
      end
   end

   assign perf_fetch_cnt = perf_fetch_q;
   assign perf_flush_cnt = perf_flush_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fetch_queue : self-checking bench for fetch_queue.                    |
// | Revision       : 1.0                                                     |
// +--------------------------------------------------------------------------+
module tb_fetch_queue;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        mem_read;
   logic [15:0] mem_address;
   logic [15:0] mem_rdata = '0;
   logic        mem_resp = 1'b0;
   logic        redirect = 1'b0;
   logic [15:0] redirect_pc = '0;
   logic        ir_valid;
   logic        ir_ready = 1'b0;
   logic [15:0] ir_out;
   logic [15:0] ir_pc;

   logic        mem_read2;
   logic [15:0] mem_address2;
   logic [15:0] mem_rdata2 = '0;
   logic        mem_resp2 = 1'b0;
   logic        ir_valid2;
   logic [15:0] ir_out2;
   logic [15:0] ir_pc2;
`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetch_cnt, perf_flush_cnt, perf_fetch_cnt2, perf_flush_cnt2;
`endif

   always #5 clk = ~clk;

   fetch_queue #(.WIDTH(16), .DEPTH(DEPTH), .RESET_PC(16'h0000), .PC_INC(2)) dut (
      .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_address(mem_address),
      .mem_rdata(mem_rdata), .mem_resp(mem_resp), .redirect(redirect),
      .redirect_pc(redirect_pc), .ir_valid(ir_valid), .ir_ready(ir_ready),
      .ir_out(ir_out), .ir_pc(ir_pc)
`ifdef FETCH_PERF_EN
      , .perf_fetch_cnt(perf_fetch_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
   );

   fetch_queue #(.WIDTH(16), .DEPTH(DEPTH), .RESET_PC(16'hFFFE), .PC_INC(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .mem_read(mem_read2), .mem_address(mem_address2),
      .mem_rdata(mem_rdata2), .mem_resp(mem_resp2), .redirect(1'b0),
      .redirect_pc(16'h0000), .ir_valid(ir_valid2), .ir_ready(1'b1),
      .ir_out(ir_out2), .ir_pc(ir_pc2)
`ifdef FETCH_PERF_EN
      , .perf_fetch_cnt(perf_fetch_cnt2), .perf_flush_cnt(perf_flush_cnt2)
`endif
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Transaction-level reference: expected instruction stream plus fetch PC.
   typedef struct packed { logic [15:0] pc; logic [15:0] ir; } ent_t;
   ent_t        q[$];
   logic [15:0] m_pc;
   bit          killed, prev_read, prev_resp, hold, force_en;
   logic [15:0] force_val, last_addr;
   int          wait_cnt, lat, max_lat, nreq, fetches, flushes;

   function automatic logic [15:0] data_of(input logic [15:0] a);
      return 16'(((a >> 1) + 16'd1) * 16'h1111);
   endfunction

   task automatic model_reset();
      q.delete();
      m_pc = 16'h0000; killed = 0; prev_read = 0; prev_resp = 0;
      wait_cnt = 0; lat = 0; nreq = 0; fetches = 0; flushes = 0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; mem_resp = 1'b0; redirect = 1'b0; ir_ready = 1'b0;
      hold = 0; force_en = 0; max_lat = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   // One cycle: called at a negedge, drives inputs, clocks, checks at the next negedge.
   task automatic step(input bit rd, input logic [15:0] rpc, input bit rdy);
      bit resp, newreq;
      newreq = mem_read && (!prev_read || prev_resp);
      if (newreq) begin
         nreq++;
         killed = 0;
         chk("req_addr", mem_address, m_pc);
         chk("req_room", q.size() < DEPTH, 1);
      end else if (mem_read) begin
         chk("addr_hold", mem_address, last_addr);
      end
      resp        = mem_read && !hold && (wait_cnt >= lat);
      mem_resp    = resp;
      mem_rdata   = force_en ? force_val : data_of(mem_address);
      redirect    = rd;
      redirect_pc = rpc;
      ir_ready    = rdy;
      if (rd) begin
         q.delete();
         m_pc = rpc;
         flushes++;
         if (mem_read && !resp) killed = 1;
      end else begin
         if (ir_valid && rdy && q.size() > 0) void'(q.pop_front());
         if (resp && !killed) begin
            q.push_back({mem_address, mem_rdata});
            m_pc = m_pc + 16'd2;
            fetches++;
         end
      end
      prev_read = mem_read;
      prev_resp = resp;
      last_addr = mem_address;
      if (resp) begin
         wait_cnt = 0;
         lat = $urandom_range(0, max_lat);
      end else if (mem_read) begin
         wait_cnt++;
      end
      @(posedge clk);
      @(negedge clk);
      redirect = 1'b0;
      chk("ir_valid", ir_valid, q.size() != 0);
      if (q.size() != 0) begin
         chk("ir_out", ir_out, q[0].ir);
         chk("ir_pc", ir_pc, q[0].pc);
      end
   endtask

   typedef struct packed {
      bit resp; logic [15:0] data; bit rdy;
      bit mr; logic [15:0] addr; bit iv; logic [15:0] out; logic [15:0] pc;
   } vec_t;
   vec_t tv [9];

   logic [15:0] pc2 [2];
   int          n2 = 0;

   initial begin
      wait (rst_n === 1'b1);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (ir_valid2 && n2 < 2) begin
            pc2[n2] = ir_pc2;
            n2++;
         end
         mem_resp2  = mem_read2;
         mem_rdata2 = mem_address2;
      end
      mem_resp2 = 1'b0;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      bit got, dead;
      logic [15:0] rpc;
      bit rd, rdy;

      tv[0] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000};
      tv[1] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000};
      tv[2] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000};
      tv[3] = '{1'b1, 16'h1111, 1'b1, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000};
      tv[4] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0002, 1'b1, 16'h1111, 16'h0000};
      tv[5] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0002, 1'b0, 16'h1111, 16'h0000};
      tv[6] = '{1'b1, 16'h2222, 1'b1, 1'b1, 16'h0002, 1'b0, 16'h1111, 16'h0000};
      tv[7] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0004, 1'b1, 16'h2222, 16'h0002};
      tv[8] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0004, 1'b0, 16'h2222, 16'h0002};

      // Basic two-word fetch, exact cycle timing.
      do_reset();
      for (int k = 0; k < 9; k++) begin
         chk("tab_mem_read", mem_read, tv[k].mr);
         if (tv[k].mr) chk("tab_addr", mem_address, tv[k].addr);
         chk("tab_ir_valid", ir_valid, tv[k].iv);
         chk("tab_ir_out", ir_out, tv[k].out);
         chk("tab_ir_pc", ir_pc, tv[k].pc);
         mem_resp  = tv[k].resp;
         mem_rdata = tv[k].data;
         ir_ready  = tv[k].rdy;
         @(negedge clk);
      end
      mem_resp = 1'b0;

      // Fill to DEPTH with zero-wait memory, then one pop re-opens fetching.
      do_reset();
      repeat (12) step(0, 16'h0, 0);
      chk("full_req_count", nreq, DEPTH);
      chk("full_mem_read", mem_read, 0);
      chk("full_valid", ir_valid, 1);
      chk("full_head_pc", ir_pc, 16'h0000);
      step(0, 16'h0, 1);
      got = 0;
      for (int i = 0; i < 6 && !got; i++) begin
         if (mem_read) got = 1;
         else step(0, 16'h0, 0);
      end
      chk("refill_seen", got, 1);
      chk("refill_addr", mem_address, 16'h0008);

      // Redirect while a request is outstanding; its late response is discarded.
      do_reset();
      got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
         if (mem_read && mem_address == 16'h0004) got = 1;
         else step(0, 16'h0, 1);
      end
      chk("reach_0004", got, 1);
      hold = 1;
      step(1, 16'h3000, 1);
      chk("flush_empty", ir_valid, 0);
      step(0, 16'h0, 1);
      step(0, 16'h0, 1);
      hold = 0; lat = 0; force_en = 1; force_val = 16'hDEAD;
      step(0, 16'h0, 1);
      force_en = 0;
      chk("drain_read", mem_read, 1);
      chk("drain_new_addr", mem_address, 16'h3000);
      dead = 0;
      for (int i = 0; i < 10; i++) begin
         if (ir_valid && ir_out == 16'hDEAD) dead = 1;
         step(0, 16'h0, 1);
      end
      chk("dead_never_seen", dead, 0);

      // Redirect coincident with a response.
      do_reset();
      got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
         if (mem_read && mem_address == 16'h0002) got = 1;
         else step(0, 16'h0, 1);
      end
      chk("reach_0002", got, 1);
      step(1, 16'h3000, 1);
      chk("coinc_read", mem_read, 1);
      chk("coinc_addr", mem_address, 16'h3000);
      chk("coinc_empty", ir_valid, 0);
      repeat (4) step(0, 16'h0, 1);

      // Asynchronous reset in the middle of a request.
      do_reset();
      hold = 1;
      repeat (3) step(0, 16'h0, 0);
      chk("pre_rst_read", mem_read, 1);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_read", mem_read, 0);
      chk("async_rst_valid", ir_valid, 0);
`ifdef FETCH_PERF_EN
      chk("async_rst_perf_fetch", perf_fetch_cnt, 0);
      chk("async_rst_perf_flush", perf_flush_cnt, 0);
`endif
      @(negedge clk);
      mem_resp = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      hold = 0;
      @(negedge clk);
      chk("restart_read", mem_read, 1);
      chk("restart_addr", mem_address, 16'h0000);
      repeat (4) step(0, 16'h0, 1);

      // Randomized traffic against the reference.
      do_reset();
      max_lat = 3;
      lat = $urandom_range(0, 3);
      for (int i = 0; i < 600; i++) begin
         rd  = ($urandom_range(0, 19) == 0);
         rpc = 16'($urandom_range(0, 65535)) & 16'hFFFE;
         rdy = (i < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
         step(rd, rpc, rdy);
      end
`ifdef FETCH_PERF_EN
      chk("perf_fetch", perf_fetch_cnt, fetches);
      chk("perf_flush", perf_flush_cnt, flushes);
`endif

      // PC wrap from RESET_PC=0xFFFE instance.
      chk("wrap_count", n2, 2);
      chk("wrap_pc0", pc2[0], 16'hFFFE);
      chk("wrap_pc1", pc2[1], 16'h0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
